// File: rtl/uart_tx_fifo_cfg_pkg.sv
// Shared encodings for the configurable buffered UART transmitter:
// parity mode codes and the framer state type.
package uart_tx_fifo_cfg_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Mode 2'b11 is reserved and behaves like "no parity".
  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_cfg_fifo.sv
// First-word-fall-through FIFO with occupancy count. A push is accepted when
// full if a pop happens in the same cycle, so the slot being freed is reused.
module uart_tx_fifo_cfg_fifo #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] r_data,
  output logic         full,
  output logic         empty,
  output logic [W:0]   count
);

  localparam int DEPTH = 2 ** W;

  logic [B-1:0] mem [DEPTH];
  logic [W-1:0] wr_ptr;
  logic [W-1:0] rd_ptr;
  logic         push;
  logic         pop;

  assign pop    = rd && !empty;
  assign push   = wr && (!full || pop);
  assign full   = (count == (W+1)'(DEPTH));
  assign empty  = (count == '0);
  assign r_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= w_data;
  end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// Buffered UART transmitter with run-time baud divisor, parity and stop-bit
// count. Framing settings are captured per frame when it leaves the FIFO.
module uart_tx_fifo_cfg
  import uart_tx_fifo_cfg_pkg::*;
#(
  parameter int DBITS = 8,
  parameter int W     = 4,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [DBITS-1:0] w_data,
  input  logic             en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
  output logic             full,
  output logic             empty,
  output logic [W:0]       count,
  output logic             busy,
  output logic             tx_done,
  output logic             tdo
);

  localparam int IDX_W = $clog2(DBITS);

  tx_state_t        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] bit_q, bit_d;
  logic [DBITS-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       pmode_q, pmode_d;
  logic             stop2_q, stop2_d;
  logic             stop_q, stop_d;
  logic             done_q, done_d;
  logic             pop;
  logic             start_frame;
  logic             tick;
  logic [DBITS-1:0] head;

  uart_tx_fifo_cfg_fifo #(
    .B (DBITS),
    .W (W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .rd     (pop),
    .w_data (w_data),
    .r_data (head),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  assign tick = (cnt_q == div_q - 1'b1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    div_d       = div_q;
    pmode_d     = pmode_q;
    stop2_d     = stop2_q;
    stop_d      = stop_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    start_frame = 1'b0;

    if (state_q != IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;

    case (state_q)
      IDLE: start_frame = en && !empty;
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == IDX_W'(DBITS - 1)) begin
            state_d = parity_on(pmode_q) ? PARITY : STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
      default: begin
        if (tick) begin
          if (stop2_q && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            done_d      = 1'b1;
            start_frame = en && !empty;
            if (!start_frame) state_d = IDLE;
          end
        end
      end
    endcase

    // A new frame latches its own copy of the line settings, so the host may
    // reprogram them at any time without corrupting the frame in flight.
    if (start_frame) begin
      pop     = 1'b1;
      state_d = START;
      cnt_d   = '0;
      shift_d = head;
      par_d   = (parity_mode == PAR_ODD) ? ~^head : ^head;
      div_d   = (baud_div == '0) ? DIV_W'(1) : baud_div;
      pmode_d = parity_mode;
      stop2_d = stop2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      div_q   <= DIV_W'(1);
      pmode_q <= PAR_NONE;
      stop2_q <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      div_q   <= div_d;
      pmode_q <= pmode_d;
      stop2_q <= stop2_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    case (state_q)
      IDLE:    tdo = 1'b1;
      START:   tdo = 1'b0;
      DATA:    tdo = shift_q[0];
      PARITY:  tdo = par_q;
      default: tdo = 1'b1;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign tx_done = done_q;

endmodule
